// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and helpers for the ID-stage hazard scoreboard.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

    // Register 0 is hardwired to zero and never tracked.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles from load issue until the loaded value is forwardable.
    localparam int LOAD_LAT = 1;

    // Number of architectural GPRs.
    localparam int NUM_REGS = 32;

    // Kind of result producer sitting in ID.
    typedef enum logic [1:0] {
        PROD_ALU    = 2'd0,
        PROD_LOAD   = 2'd1,
        PROD_MULDIV = 2'd2
    } prod_e;

    // Bits needed to hold a countdown from lat down to 0: ceil(log2(lat+1)), at least 1.
    function automatic int cnt_width(input int lat);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < lat + 1) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_countdown.sv
// Single down-counter: loads a start value, otherwise counts down to zero and stays there.
// Latency: the count updates one cycle after load/dec are sampled.
// Backpressure: none; load overrides decrement on the same cycle.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load, load_val  restart the countdown at load_val
//   dec             decrement by one when nonzero
//   cnt             current countdown value
module reg_countdown #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: stalls the ID instruction while a source/dest GPR or the mult/div unit is pending.
// Latency: stall/issue are combinational in the ID cycle; countdowns update on the next rising edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; flush overrides stall and kills the instruction.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_valid, id_rs, id_rt         ID instruction and its source registers
//   id_uses_rs, id_uses_rt         source read enables
//   id_we, id_wn                   destination write enable / register
//   id_is_load, id_is_muldiv       producer class of the ID instruction
//   flush                          ID instruction killed this cycle
//   stall, issue                   hold / advance the ID instruction
//   md_busy, pending               mult/div occupied, per-register pending bits
//   stall_count                    saturating count of stall cycles
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_we,
    input  logic [4:0]  id_wn,
    input  logic        id_is_load,
    input  logic        id_is_muldiv,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic        md_busy,
    output logic [31:0] pending,
    output logic [15:0] stall_count
);

    localparam int CW = cnt_width(MULDIV_LAT);

    prod_e          prod;
    logic           live;
    logic           src_haz;
    logic           waw_haz;
    logic           md_haz;
    logic           tracks_write;
    logic [CW-1:0]  wr_lat;
    logic [CW-1:0]  md_cnt;

    // Classify the producer; a plain ALU result is covered by EX/MEM forwarding.
    always_comb begin
        prod = PROD_ALU;
        if (id_is_load) begin
            prod = PROD_LOAD;
        end else if (id_is_muldiv) begin
            prod = PROD_MULDIV;
        end
    end

    assign tracks_write = id_we && (id_wn != REG_ZERO) && (prod != PROD_ALU);
    assign wr_lat       = (prod == PROD_LOAD) ? CW'(LOAD_LAT) : CW'(MULDIV_LAT);

    // Per-register countdowns for r = 1..31; r0 is never tracked.
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [CW-1:0] cnt_r;

        reg_countdown #(
            .W (CW)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && tracks_write && (id_wn == 5'(r))),
            .load_val (wr_lat),
            .dec      (1'b1),
            .cnt      (cnt_r)
        );

        assign pending[r] = (cnt_r != '0);
    end

    // Mult/div unit occupancy uses the same countdown.
    reg_countdown #(
        .W (CW)
    ) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && id_is_muldiv),
        .load_val (CW'(MULDIV_LAT)),
        .dec      (1'b1),
        .cnt      (md_cnt)
    );

    assign md_busy = (md_cnt != '0);

    // pending[0] is constant zero, so the explicit r0 compares are belt and braces.
    assign src_haz = (id_uses_rs && (id_rs != REG_ZERO) && pending[id_rs])
                   | (id_uses_rt && (id_rt != REG_ZERO) && pending[id_rt]);
    assign waw_haz = id_we && (id_wn != REG_ZERO) && pending[id_wn];
    assign md_haz  = id_is_muldiv && md_busy;

    assign live  = id_valid && !flush;
    assign stall = live && (src_haz || waw_haz || md_haz);
    assign issue = live && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
